pad_scanner: RTL and testbench
==============================

# pad_scanner

Multi-port, parametrised game-pad scanner that replaces the single NES controller reader. It drives one shared latch/clock pair to 1–4 pads and reads 8-bit (NES) or 16-bit (SNES) serial reports from each pad. Button state, press events accumulated since the last acknowledge, and an overrun flag are presented to the processor behind a level Data_Ready / Read_Ack handshake. The whole block runs in the SYSTEM_Clock domain and derives no internal clocks.

## Interface
- CLK_DIV, 150: pad-clock half-period in SYSTEM_Clock cycles. 150 gives 83.33 kHz at 25 MHz. Minimum 4.
- FRAME_CYCLES, 416667: cycles between latch rising edges. 416667 gives 60 Hz at 25 MHz. Must be at least 2·CLK_DIV·(BITS+1)+2.
- BITS, 8: report length per pad. Legal values are 8 and 16.
- PORTS, 1: number of pads. Legal range 1–4.
- SYSTEM_Clock  in  1  system clock, 25 MHz nominal.
- SYSTEM_Rst  in  1  reset, asynchronous, active-high.
- Serial_Data  in  PORTS  pad data lines, active-low; bit p belongs to pad p.
- Read_Ack  in  1  one-cycle pulse from the processor that consumes the current report.
- Pad_Latch  out  1  latch to all pads.
- Pad_Clock  out  1  clock to all pads; idles high.
- Buttons  out  PORTS·BITS  current state; 1 = pressed. Pad p occupies [p·BITS+BITS-1 : p·BITS].
- Pressed  out  PORTS·BITS  0→1 button transitions accumulated since the last acknowledge.
- Data_Ready  out  1  level; a new report is pending.
- Overrun  out  1  sticky; a report completed while Data_Ready was already high.

## Operation
- Each Serial_Data bit passes through a 2-flop synchroniser. Samples are inverted so that 1 means pressed.
- Sequencer states: IDLE → LATCH → SHIFT → DONE → IDLE.
- A frame counter runs freely and starts a frame every FRAME_CYCLES cycles, independent of the handshake.
- IDLE: Pad_Latch=0, Pad_Clock=1. Leave IDLE when the frame counter expires.
- LATCH: Pad_Latch=1 for 2·CLK_DIV cycles.
- SHIFT: BITS pad-clock periods. Each period is CLK_DIV cycles low followed by CLK_DIV cycles high.
- Sampling: in the first cycle of each low phase, every port shifts its synchronised, inverted bit into its LSB. After BITS shifts, the first bit read sits in the MSB.
  - NES ordering: bits [7:0] = A, B, SEL, START, UP, DOWN, LEFT, RIGHT.
- DONE (one cycle): for each port, Buttons ← shift register; Pressed ← (Read_Ack ? 0 : Pressed) | (new & ~old Buttons); Data_Ready ← 1.
- Overrun update in DONE: Overrun ← 1 if Data_Ready=1 and Read_Ack=0 in that cycle.
- Read_Ack with Data_Ready=1, outside DONE: clears Data_Ready, Pressed and Overrun on the next edge.
- Read_Ack with Data_Ready=0: ignored.
- Read_Ack in the DONE cycle: the acknowledge is absorbed. Data_Ready stays 1, Pressed holds only this frame's new presses, and Overrun is neither set nor cleared.
- Buttons always hold the most recent complete report. They never show a partial scan.

## Timing
- Reset values: Pad_Latch=0, Pad_Clock=1, Buttons=0, Pressed=0, Data_Ready=0, Overrun=0. The shift registers, synchronisers and frame counter are also cleared; state = IDLE.
- Reset asserted mid-scan aborts the scan immediately and asynchronously. The next frame starts normally after release.
- First Pad_Latch rise: first SYSTEM_Clock edge after reset release. Later rises follow every FRAME_CYCLES cycles exactly.
- With Pad_Latch rising at cycle L and D=CLK_DIV:
  - Pad_Latch is high for cycles L … L+2D-1.
  - Bit k: Pad_Clock low for L+2D+2kD … L+3D+2kD-1, then high until L+4D+2kD-1.
  - Bit k is sampled at cycle L+2D+2kD.
  - Buttons, Pressed and Data_Ready update at cycle L+2D(BITS+1). Defaults: L+2700 for 8 bits, L+5100 for 16 bits.
- All outputs are registered, with no combinational path from input to output.
- Pad_Clock and Pad_Latch are never low/high glitch-free-violated: each changes at most once per cycle, and they are never both active at once.

## Test plan
- Reset then idle, defaults, PORTS=1, pad model returns 0x5A (active-low 0xA5) → at L+2700 Buttons=0x5A and Data_Ready=1. Pad_Latch width 300 cycles; exactly 8 Pad_Clock low pulses of 150 cycles each.
- PORTS=2, BITS=16, pads return 0x8001 and 0x7FFE → Buttons=0x7FFE_8001 at L+5100, with MSB = first bit read.
- Two frames with no ack, frame1 0x01 and frame2 0x03 → Overrun=1, Pressed=0x03, Buttons=0x03. Then one Read_Ack → Data_Ready, Overrun and Pressed all 0 on the next cycle.
- Read_Ack pulsed exactly in the DONE cycle → Data_Ready stays 1, Overrun stays 0, Pressed holds only the new frame's presses.
- Button released (0x80→0x00) then pressed again (0x00→0x80) across frames → Pressed bit 7 set only on the 0→1 frame.
- SYSTEM_Rst pulsed mid-SHIFT at bit 4 → all outputs at reset values immediately. The next latch rises on the first edge after release, and the complete report after it is correct.

Source files
------------

// File: rtl/pad_scanner_if.sv
// pad_scanner_if: processor-side report/handshake bundle of the pad scanner.
//   Read_Ack    one-cycle acknowledge from the processor
//   Buttons     current button state, PORTS*BITS, 1 = pressed
//   Pressed     0->1 transitions accumulated since the last acknowledge
//   Data_Ready  level, a new report is pending
//   Overrun     sticky, a report completed while Data_Ready was still high
// master = processor side, slave = scanner side.
interface pad_scanner_if #(
    parameter int unsigned PORTS = 1,
    parameter int unsigned BITS  = 8
);
    logic                    Read_Ack;
    logic [PORTS*BITS-1:0]   Buttons;
    logic [PORTS*BITS-1:0]   Pressed;
    logic                    Data_Ready;
    logic                    Overrun;

    modport master (output Read_Ack, input Buttons, Pressed, Data_Ready, Overrun);
    modport slave  (input Read_Ack, output Buttons, Pressed, Data_Ready, Overrun);
endinterface

// File: rtl/pad_scanner.sv
// pad_scanner: scans 1-4 NES/SNES game pads over a shared latch/clock pair.
// A free-running frame counter starts a scan every FRAME_CYCLES cycles:
// latch for 2*CLK_DIV cycles, then BITS pad-clock periods (CLK_DIV low,
// CLK_DIV high), sampling each pad's active-low data at the start of every
// low phase. Completed reports are published through the host interface.
// Ports:
//   SYSTEM_Clock  system clock
//   SYSTEM_Rst    asynchronous active-high reset
//   Serial_Data   pad data lines, active-low, bit p = pad p
//   Pad_Latch     latch to all pads
//   Pad_Clock     clock to all pads, idles high
//   host          report/handshake bundle (slave side)
module pad_scanner #(
    parameter int unsigned CLK_DIV      = 150,
    parameter int unsigned FRAME_CYCLES = 416667,
    parameter int unsigned BITS         = 8,
    parameter int unsigned PORTS        = 1
) (
    input  logic             SYSTEM_Clock,
    input  logic             SYSTEM_Rst,
    input  logic [PORTS-1:0] Serial_Data,
    output logic             Pad_Latch,
    output logic             Pad_Clock,
    pad_scanner_if.slave     host
);
    localparam int unsigned W  = PORTS * BITS;
    localparam int unsigned FW = $clog2(FRAME_CYCLES);
    localparam int unsigned PW = $clog2(2 * CLK_DIV);
    localparam int unsigned BW = $clog2(BITS);

    localparam logic [FW-1:0] FRAME_LAST  = FW'(FRAME_CYCLES - 1);
    localparam logic [PW-1:0] HALF_LAST   = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] PERIOD_LAST = PW'(2 * CLK_DIV - 1);
    localparam logic [PW-1:0] DONE_AT     = PW'(2 * CLK_DIV - 2);
    localparam logic [BW-1:0] BIT_LAST    = BW'(BITS - 1);

    typedef enum logic [1:0] {IDLE, LATCH, SHIFT, DONE} state_t;

    state_t          state;
    logic [FW-1:0]   frame_cnt;
    logic [PW-1:0]   phase;
    logic [BW-1:0]   bit_idx;
    logic [PORTS-1:0] sync1;
    logic [PORTS-1:0] sync2;
    logic [W-1:0]    shreg;
    logic [W-1:0]    shifted;
    logic [W-1:0]    buttons;
    logic [W-1:0]    pressed;
    logic            data_ready;
    logic            overrun;
    logic            ack;
    logic            frame_start;

    assign ack         = host.Read_Ack;
    assign frame_start = (frame_cnt == '0);

    assign host.Buttons    = buttons;
    assign host.Pressed    = pressed;
    assign host.Data_Ready = data_ready;
    assign host.Overrun    = overrun;

    // Every port shifts its synchronised, inverted sample into its LSB, so the
    // first bit read ends up in the MSB of that port's field.
    always_comb begin
        shifted = shreg;
        for (int unsigned p = 0; p < PORTS; p++) begin
            shifted[p*BITS +: BITS] = {shreg[p*BITS +: BITS-1], ~sync2[p]};
        end
    end

    always_ff @(posedge SYSTEM_Clock or posedge SYSTEM_Rst) begin
        if (SYSTEM_Rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= Serial_Data;
            sync2 <= sync1;
        end
    end

    // Free-running: frame starts are independent of the handshake.
    always_ff @(posedge SYSTEM_Clock or posedge SYSTEM_Rst) begin
        if (SYSTEM_Rst) begin
            frame_cnt <= '0;
        end else if (frame_cnt == FRAME_LAST) begin
            frame_cnt <= '0;
        end else begin
            frame_cnt <= frame_cnt + FW'(1);
        end
    end

    always_ff @(posedge SYSTEM_Clock or posedge SYSTEM_Rst) begin
        if (SYSTEM_Rst) begin
            state      <= IDLE;
            Pad_Latch  <= 1'b0;
            Pad_Clock  <= 1'b1;
            phase      <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            buttons    <= '0;
            pressed    <= '0;
            data_ready <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            // Acknowledge outside DONE; in DONE the report update below owns
            // these registers and absorbs the acknowledge.
            if (state != DONE && ack && data_ready) begin
                data_ready <= 1'b0;
                pressed    <= '0;
                overrun    <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (frame_start) begin
                        state     <= LATCH;
                        Pad_Latch <= 1'b1;
                        phase     <= '0;
                    end
                end
                LATCH: begin
                    if (phase == PERIOD_LAST) begin
                        state     <= SHIFT;
                        Pad_Latch <= 1'b0;
                        Pad_Clock <= 1'b0;
                        shreg     <= shifted;
                        phase     <= '0;
                        bit_idx   <= '0;
                    end else begin
                        phase <= phase + PW'(1);
                    end
                end
                SHIFT: begin
                    phase <= phase + PW'(1);
                    if (phase == HALF_LAST) begin
                        Pad_Clock <= 1'b1;
                    end
                    // The last high phase ends one cycle early; DONE fills that
                    // cycle so the report lands exactly at L+2*CLK_DIV*(BITS+1).
                    if (bit_idx == BIT_LAST && phase == DONE_AT) begin
                        state <= DONE;
                    end else if (phase == PERIOD_LAST) begin
                        Pad_Clock <= 1'b0;
                        shreg     <= shifted;
                        bit_idx   <= bit_idx + BW'(1);
                        phase     <= '0;
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    buttons    <= shreg;
                    pressed    <= (ack ? '0 : pressed) | (shreg & ~buttons);
                    data_ready <= 1'b1;
                    if (data_ready && !ack) begin
                        overrun <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pad_scanner.sv
// tb_pad_scanner: directed bench for pad_scanner with an NES instance
// (1 port, 8 bits) and an SNES instance (2 ports, 16 bits), both with a
// short pad-clock divider. Behavioural pad models load on Pad_Latch rise and
// shift on Pad_Clock rise, driving active-low data.
module tb_pad_scanner;
    localparam int unsigned D        = 4;
    localparam int unsigned NES_DONE  = 2 * D * (8 + 1);
    localparam int unsigned SNES_DONE = 2 * D * (16 + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // NES instance
    logic       nes_latch, nes_clk;
    logic [0:0] nes_sd;
    logic [7:0] nes_pat = '0;
    logic [7:0] nes_sr  = '0;
    pad_scanner_if #(.PORTS(1), .BITS(8)) nes_bus ();

    pad_scanner #(.CLK_DIV(D), .FRAME_CYCLES(100), .BITS(8), .PORTS(1)) u_nes (
        .SYSTEM_Clock (clk),
        .SYSTEM_Rst   (rst),
        .Serial_Data  (nes_sd),
        .Pad_Latch    (nes_latch),
        .Pad_Clock    (nes_clk),
        .host         (nes_bus.slave)
    );

    always @(posedge nes_latch or posedge nes_clk) begin
        if (nes_latch) nes_sr <= nes_pat;
        else           nes_sr <= {nes_sr[6:0], 1'b0};
    end
    assign nes_sd = ~nes_sr[7];

    // SNES instance
    logic        snes_latch, snes_clk;
    logic [1:0]  snes_sd;
    logic [15:0] s0_pat = '0, s1_pat = '0;
    logic [15:0] s0_sr  = '0, s1_sr  = '0;
    pad_scanner_if #(.PORTS(2), .BITS(16)) snes_bus ();

    pad_scanner #(.CLK_DIV(D), .FRAME_CYCLES(200), .BITS(16), .PORTS(2)) u_snes (
        .SYSTEM_Clock (clk),
        .SYSTEM_Rst   (rst),
        .Serial_Data  (snes_sd),
        .Pad_Latch    (snes_latch),
        .Pad_Clock    (snes_clk),
        .host         (snes_bus.slave)
    );

    always @(posedge snes_latch or posedge snes_clk) begin
        if (snes_latch) begin
            s0_sr <= s0_pat;
            s1_sr <= s1_pat;
        end else begin
            s0_sr <= {s0_sr[14:0], 1'b0};
            s1_sr <= {s1_sr[14:0], 1'b0};
        end
    end
    assign snes_sd = {~s1_sr[15], ~s0_sr[15]};

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Returns at the first negedge where the NES latch is seen high after low.
    task automatic wait_nes_latch(output int n);
        logic prev;
        logic found;
        prev  = nes_latch;
        found = 1'b0;
        n     = 0;
        while (!found && n < 400) begin
            @(negedge clk);
            n++;
            if (!prev && nes_latch) found = 1'b1;
            prev = nes_latch;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL nes_latch_timeout: no latch rise within %0d cycles", n);
        end
    endtask

    task automatic wait_snes_latch(output int n);
        logic prev;
        logic found;
        prev  = snes_latch;
        found = 1'b0;
        n     = 0;
        while (!found && n < 600) begin
            @(negedge clk);
            n++;
            if (!prev && snes_latch) found = 1'b1;
            prev = snes_latch;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL snes_latch_timeout: no latch rise within %0d cycles", n);
        end
    endtask

    task automatic next_update();
        int n;
        wait_nes_latch(n);
        repeat (NES_DONE) @(negedge clk);
    endtask

    task automatic nes_ack();
        nes_bus.Read_Ack = 1'b1;
        @(negedge clk);
        nes_bus.Read_Ack = 1'b0;
    endtask

    // Leaves the NES instance with Buttons=p and everything acknowledged.
    task automatic settle(input logic [7:0] p);
        nes_pat = p;
        next_update();
        next_update();
        nes_ack();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        nes_bus.Read_Ack  = 1'b0;
        snes_bus.Read_Ack = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (nes_latch !== 1'b0) begin errors++; $display("FAIL rst_latch: got %b want 0", nes_latch); end
        checks++; if (nes_clk !== 1'b1) begin errors++; $display("FAIL rst_clock: got %b want 1", nes_clk); end
        checks++; if (nes_bus.Buttons !== 8'h00) begin errors++; $display("FAIL rst_buttons: got %h want 00", nes_bus.Buttons); end
        checks++; if (nes_bus.Pressed !== 8'h00) begin errors++; $display("FAIL rst_pressed: got %h want 00", nes_bus.Pressed); end
        checks++; if (nes_bus.Data_Ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", nes_bus.Data_Ready); end
        checks++; if (nes_bus.Overrun !== 1'b0) begin errors++; $display("FAIL rst_overrun: got %b want 0", nes_bus.Overrun); end
        checks++; if (snes_bus.Buttons !== 32'h0) begin errors++; $display("FAIL rst_snes_buttons: got %h want 0", snes_bus.Buttons); end
        rst = 1'b0;
    endtask

    task automatic test_nes_frame();
        int n;
        int latch_hi, pulses, badw, overlap, lowrun;
        nes_pat = 8'h5A;
        wait_nes_latch(n);
        checks++; if (n !== 1) begin errors++; $display("FAIL first_latch: got %0d cycles want 1", n); end
        latch_hi = 0; pulses = 0; badw = 0; overlap = 0; lowrun = 0;
        for (int i = 0; i <= int'(NES_DONE); i++) begin
            if (i > 0) @(negedge clk);
            if (nes_latch) latch_hi++;
            if (nes_latch && !nes_clk) overlap++;
            if (!nes_clk) lowrun++;
            else if (lowrun != 0) begin
                pulses++;
                if (lowrun != int'(D)) badw++;
                lowrun = 0;
            end
            if (i == int'(NES_DONE) - 1) begin
                checks++; if (nes_bus.Data_Ready !== 1'b0) begin errors++; $display("FAIL early_ready: got %b want 0", nes_bus.Data_Ready); end
                checks++; if (nes_bus.Buttons !== 8'h00) begin errors++; $display("FAIL partial_buttons: got %h want 00", nes_bus.Buttons); end
            end
        end
        checks++; if (nes_bus.Buttons !== 8'h5A) begin errors++; $display("FAIL nes_buttons: got %h want 5a", nes_bus.Buttons); end
        checks++; if (nes_bus.Pressed !== 8'h5A) begin errors++; $display("FAIL nes_pressed: got %h want 5a", nes_bus.Pressed); end
        checks++; if (nes_bus.Data_Ready !== 1'b1) begin errors++; $display("FAIL nes_ready: got %b want 1", nes_bus.Data_Ready); end
        checks++; if (latch_hi !== 2 * int'(D)) begin errors++; $display("FAIL latch_width: got %0d want %0d", latch_hi, 2 * D); end
        checks++; if (pulses !== 8) begin errors++; $display("FAIL clock_pulses: got %0d want 8", pulses); end
        checks++; if (badw !== 0) begin errors++; $display("FAIL clock_width: got %0d bad pulses want 0", badw); end
        checks++; if (overlap !== 0) begin errors++; $display("FAIL latch_clock_overlap: got %0d want 0", overlap); end
        nes_ack();
        checks++; if (nes_bus.Data_Ready !== 1'b0) begin errors++; $display("FAIL ack_ready: got %b want 0", nes_bus.Data_Ready); end
        checks++; if (nes_bus.Pressed !== 8'h00) begin errors++; $display("FAIL ack_pressed: got %h want 00", nes_bus.Pressed); end
        wait_nes_latch(n);
        checks++; if (n !== 100 - int'(NES_DONE) - 1) begin errors++; $display("FAIL frame_period: got %0d want %0d", n, 100 - NES_DONE - 1); end
    endtask

    task automatic test_snes();
        int n;
        s0_pat = 16'h8001;
        s1_pat = 16'h7FFE;
        wait_snes_latch(n);
        repeat (SNES_DONE - 1) @(negedge clk);
        checks++; if (snes_bus.Buttons !== 32'h0) begin errors++; $display("FAIL snes_early: got %h want 0", snes_bus.Buttons); end
        @(negedge clk);
        checks++; if (snes_bus.Buttons !== 32'h7FFE_8001) begin errors++; $display("FAIL snes_buttons: got %h want 7ffe8001", snes_bus.Buttons); end
        checks++; if (snes_bus.Pressed !== 32'h7FFE_8001) begin errors++; $display("FAIL snes_pressed: got %h want 7ffe8001", snes_bus.Pressed); end
    endtask

    task automatic test_overrun();
        settle(8'h00);
        nes_pat = 8'h01;
        next_update();
        checks++; if (nes_bus.Overrun !== 1'b0) begin errors++; $display("FAIL ovr_first: got %b want 0", nes_bus.Overrun); end
        nes_pat = 8'h03;
        next_update();
        checks++; if (nes_bus.Overrun !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b want 1", nes_bus.Overrun); end
        checks++; if (nes_bus.Pressed !== 8'h03) begin errors++; $display("FAIL ovr_pressed: got %h want 03", nes_bus.Pressed); end
        checks++; if (nes_bus.Buttons !== 8'h03) begin errors++; $display("FAIL ovr_buttons: got %h want 03", nes_bus.Buttons); end
        nes_ack();
        checks++; if (nes_bus.Overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b want 0", nes_bus.Overrun); end
        checks++; if (nes_bus.Data_Ready !== 1'b0) begin errors++; $display("FAIL ovr_ready_clear: got %b want 0", nes_bus.Data_Ready); end
        checks++; if (nes_bus.Pressed !== 8'h00) begin errors++; $display("FAIL ovr_pressed_clear: got %h want 00", nes_bus.Pressed); end
    endtask

    task automatic test_ack_in_done();
        int n;
        settle(8'h80);
        nes_pat = 8'h80;
        next_update();
        nes_pat = 8'h81;
        wait_nes_latch(n);
        repeat (NES_DONE - 1) @(negedge clk);
        nes_bus.Read_Ack = 1'b1;
        @(negedge clk);
        nes_bus.Read_Ack = 1'b0;
        checks++; if (nes_bus.Data_Ready !== 1'b1) begin errors++; $display("FAIL done_ack_ready: got %b want 1", nes_bus.Data_Ready); end
        checks++; if (nes_bus.Overrun !== 1'b0) begin errors++; $display("FAIL done_ack_overrun: got %b want 0", nes_bus.Overrun); end
        checks++; if (nes_bus.Pressed !== 8'h01) begin errors++; $display("FAIL done_ack_pressed: got %h want 01", nes_bus.Pressed); end
        checks++; if (nes_bus.Buttons !== 8'h81) begin errors++; $display("FAIL done_ack_buttons: got %h want 81", nes_bus.Buttons); end
        nes_ack();
        checks++; if (nes_bus.Data_Ready !== 1'b0) begin errors++; $display("FAIL done_ack_later: got %b want 0", nes_bus.Data_Ready); end
    endtask

    task automatic test_release_repress();
        settle(8'h80);
        nes_pat = 8'h00;
        next_update();
        checks++; if (nes_bus.Pressed !== 8'h00) begin errors++; $display("FAIL release_pressed: got %h want 00", nes_bus.Pressed); end
        nes_ack();
        nes_pat = 8'h80;
        next_update();
        checks++; if (nes_bus.Pressed !== 8'h80) begin errors++; $display("FAIL repress_pressed: got %h want 80", nes_bus.Pressed); end
        nes_ack();
    endtask

    task automatic test_reset_mid_scan();
        int n;
        settle(8'h00);
        nes_pat = 8'h3C;
        wait_nes_latch(n);
        repeat (2 * D + 8 * D) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (nes_clk !== 1'b1 || nes_latch !== 1'b0) begin errors++; $display("FAIL mid_rst_pins: got clk=%b latch=%b want 1/0", nes_clk, nes_latch); end
        checks++; if (nes_bus.Buttons !== 8'h00 || nes_bus.Pressed !== 8'h00) begin errors++; $display("FAIL mid_rst_regs: got %h/%h want 00/00", nes_bus.Buttons, nes_bus.Pressed); end
        checks++; if (nes_bus.Data_Ready !== 1'b0 || nes_bus.Overrun !== 1'b0) begin errors++; $display("FAIL mid_rst_flags: got %b/%b want 0/0", nes_bus.Data_Ready, nes_bus.Overrun); end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wait_nes_latch(n);
        checks++; if (n !== 1) begin errors++; $display("FAIL mid_rst_relatch: got %0d cycles want 1", n); end
        repeat (NES_DONE) @(negedge clk);
        checks++; if (nes_bus.Buttons !== 8'h3C) begin errors++; $display("FAIL mid_rst_buttons: got %h want 3c", nes_bus.Buttons); end
        checks++; if (nes_bus.Data_Ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready: got %b want 1", nes_bus.Data_Ready); end
    endtask

    initial begin
        nes_bus.Read_Ack  = 1'b0;
        snes_bus.Read_Ack = 1'b0;
        test_reset();
        test_nes_frame();
        test_snes();
        test_overrun();
        test_ack_in_done();
        test_release_repress();
        test_reset_mid_scan();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
